// File: rtl/mesh_phase_sequencer.sv
// mesh_phase_sequencer: central phase sequencer for the PE mesh.
// Broadcasts one phase code and step counter to every PE. One round is COMPUTE, then an
// address-routing pass (PUT_ADDR, sort, row-align, col-align), then a data-return pass
// (LOAD_DATA, sort, row-align, col-align). A host starts a run with a round count and gets a
// one-cycle done pulse when the run completes.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   i_start   start a run (honoured only when idle)
//   i_rounds  number of rounds, captured on an accepted start
//   i_abort   synchronous abort back to idle, no done pulse
//   o_busy    run in progress
//   o_done    one-cycle completion pulse
//   o_top     top phase code
//   o_bottom  bottom phase code
//   o_step    cycle index within the current sub-phase (ROM address during SORT)
//   o_rom_en  high when busy and o_bottom is SORT
//   o_round   index of the current round
module mesh_phase_sequencer #(
  parameter int unsigned SQRT_N         = 32,
  parameter int unsigned SORT_CYCLES    = 222,
  parameter int unsigned COMPUTE_CYCLES = 3,
  parameter int unsigned CNT_WIDTH      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [7:0]           i_rounds,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2:0]           o_top,
  output logic [2:0]           o_bottom,
  output logic [CNT_WIDTH-1:0] o_step,
  output logic                 o_rom_en,
  output logic [7:0]           o_round
);

  localparam logic [CNT_WIDTH-1:0] ComputeLast = CNT_WIDTH'(COMPUTE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SortLast    = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] AlignLast   = CNT_WIDTH'(SQRT_N - 1);

  typedef enum logic [3:0] {
    StIdle,
    StCompute,
    StPutAddr,
    StASort,
    StARow,
    StACol,
    StLoadData,
    StDSort,
    StDRow,
    StDCol
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           rounds_q, rounds_d;
  logic [7:0]           round_d;
  logic [CNT_WIDTH-1:0] step_d;
  logic                 done_d;
  logic                 last_step;
  logic [2:0]           top_d, bottom_d;

  // o_step is the step register itself; compare it against the current state's last index.
  always_comb begin
    last_step = 1'b0;
    unique case (state_q)
      StCompute:                       last_step = (o_step == ComputeLast);
      StPutAddr, StLoadData:           last_step = 1'b1;
      StASort, StDSort:                last_step = (o_step == SortLast);
      StARow, StACol, StDRow, StDCol:  last_step = (o_step == AlignLast);
      default:                         last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rounds_d = rounds_q;
    round_d  = o_round;
    done_d   = 1'b0;
    if (i_abort) begin
      // Abort beats start and completion; the round index is kept for the host to inspect.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            rounds_d = i_rounds;
            round_d  = 8'd0;
            if (i_rounds == 8'd0) begin
              done_d = 1'b1;
            end else begin
              state_d = StCompute;
            end
          end
        end
        StCompute:  if (last_step) state_d = StPutAddr;
        StPutAddr:  if (last_step) state_d = StASort;
        StASort:    if (last_step) state_d = StARow;
        StARow:     if (last_step) state_d = StACol;
        StACol:     if (last_step) state_d = StLoadData;
        StLoadData: if (last_step) state_d = StDSort;
        StDSort:    if (last_step) state_d = StDRow;
        StDRow:     if (last_step) state_d = StDCol;
        StDCol: begin
          if (last_step) begin
            // Widen to 9 bits so round 255 + 1 does not wrap.
            if (({1'b0, o_round} + 9'd1) < {1'b0, rounds_q}) begin
              state_d = StCompute;
              round_d = o_round + 8'd1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (state_d != state_q || state_q == StIdle) begin
      step_d = '0;
    end else begin
      step_d = o_step + CNT_WIDTH'(1);
    end
  end

  // Phase codes decoded from the next state so the outputs leave the flops directly.
  always_comb begin
    top_d    = 3'b010;
    bottom_d = 3'b111;
    unique case (state_d)
      StIdle, StCompute: begin top_d = 3'b010; bottom_d = 3'b111; end
      StPutAddr:         begin top_d = 3'b111; bottom_d = 3'b111; end
      StASort:           begin top_d = 3'b000; bottom_d = 3'b000; end
      StARow:            begin top_d = 3'b000; bottom_d = 3'b001; end
      StACol:            begin top_d = 3'b000; bottom_d = 3'b010; end
      StLoadData:        begin top_d = 3'b011; bottom_d = 3'b111; end
      StDSort:           begin top_d = 3'b001; bottom_d = 3'b000; end
      StDRow:            begin top_d = 3'b001; bottom_d = 3'b001; end
      StDCol:            begin top_d = 3'b001; bottom_d = 3'b010; end
      default:           begin top_d = 3'b010; bottom_d = 3'b111; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rounds_q <= 8'd0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_top    <= 3'b010;
      o_bottom <= 3'b111;
      o_step   <= '0;
      o_rom_en <= 1'b0;
      o_round  <= 8'd0;
    end else begin
      state_q  <= state_d;
      rounds_q <= rounds_d;
      o_busy   <= (state_d != StIdle);
      o_done   <= done_d;
      o_top    <= top_d;
      o_bottom <= bottom_d;
      o_step   <= step_d;
      o_rom_en <= (state_d != StIdle) && (bottom_d == 3'b000);
      o_round  <= round_d;
    end
  end

endmodule

// File: tb/tb_mesh_phase_sequencer.sv
// Scoreboard bench for mesh_phase_sequencer. Expected per-cycle output vectors are expanded
// from the phase table when stimulus is driven, then popped and compared after each edge.
module tb_mesh_phase_sequencer;

  localparam int unsigned SqrtN   = 4;
  localparam int unsigned SortCyc = 10;
  localparam int unsigned CompCyc = 3;
  localparam int unsigned CntW    = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [7:0]      i_rounds;
  logic            i_abort;
  logic            o_busy;
  logic            o_done;
  logic [2:0]      o_top;
  logic [2:0]      o_bottom;
  logic [CntW-1:0] o_step;
  logic            o_rom_en;
  logic [7:0]      o_round;

  int checks = 0;
  int errors = 0;

  // Packed vector: {busy, done, top, bottom, step, rom_en, round}
  logic [26:0] exp_q[$];

  int ph_top[9] = '{2, 7, 0, 0, 0, 3, 1, 1, 1};
  int ph_bot[9] = '{7, 7, 0, 1, 2, 7, 0, 1, 2};
  int ph_dur[9] = '{CompCyc, 1, SortCyc, SqrtN, SqrtN, 1, SortCyc, SqrtN, SqrtN};

  mesh_phase_sequencer #(
    .SQRT_N        (SqrtN),
    .SORT_CYCLES   (SortCyc),
    .COMPUTE_CYCLES(CompCyc),
    .CNT_WIDTH     (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_rounds (i_rounds),
    .i_abort  (i_abort),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_top    (o_top),
    .o_bottom (o_bottom),
    .o_step   (o_step),
    .o_rom_en (o_rom_en),
    .o_round  (o_round)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] pack(input int busy, input int done, input int top,
                                       input int bot, input int step, input int rom,
                                       input int round);
    return {1'(busy), 1'(done), 3'(top), 3'(bot), 10'(step), 1'(rom), 8'(round)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {o_busy, o_done, o_top, o_bottom, o_step, o_rom_en, o_round};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic push_idle(input int round);
    exp_q.push_back(pack(0, 0, 2, 7, 0, 0, round));
  endtask

  task automatic push_run(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      for (int p = 0; p < 9; p++) begin
        for (int s = 0; s < ph_dur[p]; s++) begin
          exp_q.push_back(pack(1, 0, ph_top[p], ph_bot[p], s, (ph_bot[p] == 0) ? 1 : 0, r));
        end
      end
    end
    exp_q.push_back(pack(0, 1, 2, 7, 0, 0, rounds - 1));
  endtask

  task automatic tick(input string tag);
    logic [26:0] want;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      check(tag, 32'(dut_vec()), 32'(want));
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) tick(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    i_start  = 1'b0;
    i_rounds = 8'd0;
    i_abort  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(dut_vec()), 32'(pack(0, 0, 2, 7, 0, 0, 0)));
    rst = 1'b0;

    for (int k = 0; k < 5; k++) push_idle(0);
    ticks(5, "idle");

    // Single round: 41 run cycles, then done.
    i_start  = 1'b1;
    i_rounds = 8'd1;
    push_run(1);
    tick("run1");
    i_start = 1'b0;
    ticks(41, "run1");
    push_idle(0);
    tick("run1_after");

    // Three rounds with a stray start mid-run that must not alter the round count.
    i_start  = 1'b1;
    i_rounds = 8'd3;
    push_run(3);
    tick("run3");
    i_start = 1'b0;
    for (int c = 2; c <= 124; c++) begin
      if (c == 20) begin
        i_start  = 1'b1;
        i_rounds = 8'd1;
      end
      tick("run3");
      i_start = 1'b0;
    end
    push_idle(2);
    tick("run3_after");

    // Zero rounds: done next cycle, never busy.
    i_start  = 1'b1;
    i_rounds = 8'd0;
    exp_q.push_back(pack(0, 1, 2, 7, 0, 0, 0));
    tick("zero");
    i_start = 1'b0;
    push_idle(0);
    tick("zero_after");

    // Abort in round 1, A_ROW step 2 (cycle 58 of the run); round index is retained.
    i_start  = 1'b1;
    i_rounds = 8'd2;
    push_run(2);
    tick("abort_run");
    i_start = 1'b0;
    ticks(57, "abort_run");
    i_abort = 1'b1;
    exp_q.delete();
    push_idle(1);
    tick("abort");
    i_abort = 1'b0;
    push_idle(1);
    push_idle(1);
    ticks(2, "abort_after");

    // Start and abort together while idle: abort wins.
    i_start  = 1'b1;
    i_abort  = 1'b1;
    i_rounds = 8'd1;
    push_idle(1);
    tick("start_abort");
    i_start = 1'b0;
    i_abort = 1'b0;
    push_idle(1);
    push_idle(1);
    ticks(2, "start_abort_after");

    // Async reset during D_SORT step 5 (cycle 29), then a clean full run.
    i_start  = 1'b1;
    i_rounds = 8'd1;
    push_run(1);
    tick("rst_run");
    i_start = 1'b0;
    ticks(28, "rst_run");
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 32'(dut_vec()), 32'(pack(0, 0, 2, 7, 0, 0, 0)));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    i_start  = 1'b1;
    i_rounds = 8'd1;
    push_run(1);
    tick("post_rst");
    i_start = 1'b0;
    ticks(41, "post_rst");
    push_idle(0);
    push_idle(0);
    ticks(2, "post_rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
